// File: rtl/dmem_bus_pkg.sv
// Shared definitions for the MEM-stage data-memory bus controller:
// FSM state encoding, the default read-error pattern, the word-align mask
// and the width of the bus timeout counter.
package dmem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;
  localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;
  localparam int          CNT_W         = 8;

  // Clear the byte-offset bits so the bus only ever sees word addresses.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Clear/enable wait-cycle counter. tc is high in the enabled cycle whose
// increment would make the count reach LIMIT, i.e. in the LIMIT-th
// consecutive enabled cycle, so the owner can abort at the end of it.
module bus_timeout_cnt
  import dmem_bus_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  // Count enabled cycles; clear has priority so a new wait starts at zero.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= cnt + CNT_W'(1);
  end

  assign tc = en & (cnt == LAST);

endmodule

// File: rtl/dmem_bus_ctrl.sv
// MEM-stage data-memory controller: turns memreadM/memwriteM into a single
// outstanding req/ready bus transfer, stalls the pipeline while it is
// pending, drops misaligned word accesses and aborts on bus timeout.
// Optional build macro DMEM_WRITE_BUFFER_EN adds a 1-entry posted write
// buffer so aligned stores do not stall the core.
module dmem_bus_ctrl
  import dmem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  output logic [31:0] rdataM,
  output logic        stallM,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

`ifdef DMEM_WRITE_BUFFER_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  state_t state, state_nxt;

  logic access, is_write, is_load, aligned;
  logic done, tmo, cnt_en, cnt_tc;
  logic start, post, misalign, stall_c;
  logic wb_busy;

  // Both strobes high is illegal from the core; the store wins.
  assign access   = memreadM | memwriteM;
  assign is_write = memwriteM;
  assign is_load  = memreadM & ~memwriteM;
  assign aligned  = (addrM[1:0] == 2'b00);

  // A ready while no request is outstanding is not a completion.
  assign done   = bus_req & bus_ready;
  assign cnt_en = (state == WAIT) | wb_busy;
  assign tmo    = cnt_tc & ~done;

  bus_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_tmo_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr   (~cnt_en),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  // Next-state and per-cycle control decode.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    post      = 1'b0;
    misalign  = 1'b0;
    stall_c   = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (wb_busy) begin
            stall_c = 1'b1;
          end else if (!aligned) begin
            misalign = 1'b1;
          end else if (is_write && WB_EN) begin
            post = 1'b1;
          end else begin
            start     = 1'b1;
            stall_c   = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        if (done || tmo) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset also forces the stall low so the core is never held in reset.
  assign stallM = rst & stall_c;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Bus request channel: launched from IDLE, held until completion/abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else if (start || post) begin
      bus_req   <= 1'b1;
      bus_we    <= is_write;
      bus_addr  <= word_align(addrM);
      bus_wdata <= wdataM;
    end else if (done || tmo) begin
      bus_req   <= 1'b0;
    end
  end

  // Posted-write occupancy; never set when the buffer is not built in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          wb_busy <= 1'b0;
    else if (post)                     wb_busy <= 1'b1;
    else if (wb_busy && (done || tmo)) wb_busy <= 1'b0;
  end

  // Error pulses, each one cycle wide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      addr_err <= misalign;
      bus_err  <= tmo;
    end
  end

  // Load data register: holds until the next completed, dropped or aborted load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdataM <= '0;
    end else if (misalign && is_load) begin
      rdataM <= '0;
    end else if (state == WAIT && !bus_we) begin
      if (done)     rdataM <= bus_rdata;
      else if (tmo) rdataM <= ERR_RDATA;
    end
  end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed, self-checking bench for dmem_bus_ctrl (default build, no
// posted write buffer). Expected load data goes into a scoreboard queue at
// stimulus time and is popped when the controller reaches its response.
module tb_dmem_bus_ctrl;

  localparam int          TMO    = 4;
  localparam logic [31:0] ERR    = 32'hDEAD_BEEF;
  localparam int          BUDGET = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        memreadM, memwriteM;
  logic [31:0] addrM, wdataM;
  logic [31:0] rdataM;
  logic        stallM, addr_err, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rdata_model = '0;
  int          last_resp, last_req;

  dmem_bus_ctrl #(
    .TIMEOUT_CYC (TMO),
    .ERR_RDATA   (ERR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memreadM  (memreadM),
    .memwriteM (memwriteM),
    .addrM     (addrM),
    .wdataM    (wdataM),
    .rdataM    (rdataM),
    .stallM    (stallM),
    .addr_err  (addr_err),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_rdata(input string tag);
    if (exp_q.size() == 0) check({tag, "_q_empty"}, 32'd0, 32'd1);
    else                   check(tag, rdataM, exp_q.pop_front());
  endtask

  // One aligned transfer. Starts and ends on a falling edge; ready_at is the
  // WAIT cycle (1-based) in which bus_ready is driven, 0 means never.
  task automatic run_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int ready_at, input logic [31:0] rd);
    int n_stall = 0, n_wait = 0, req_cyc = -1, start_cyc;
    bit resp = 1'b0;
    bit timed_out = (ready_at == 0);
    start_cyc = cyc;
    if (!wr) rdata_model = timed_out ? ERR : rd;
    exp_q.push_back(rdata_model);
    memreadM = !wr; memwriteM = wr; addrM = addr; wdataM = wd;
    for (int i = 0; i < BUDGET && !resp; i++) begin
      #1;
      if (stallM === 1'b1) begin
        n_stall++;
        check("bus_err_quiet", bus_err, 1'b0);
        if (bus_req === 1'b1) begin
          n_wait++;
          if (req_cyc < 0) req_cyc = cyc;
          check("bus_addr", bus_addr, {addr[31:2], 2'b00});
          check("bus_we", bus_we, wr);
          check("bus_wdata", bus_wdata, wd);
          bus_ready = (n_wait == ready_at);
          bus_rdata = bus_ready ? rd : 32'h0;
        end
        @(posedge clk);
        @(negedge clk);
      end else begin
        resp = 1'b1;
      end
    end
    if (!resp) check("wait_bound", n_stall, BUDGET - 1);
    check("stall_cycles", n_stall, 1 + (timed_out ? TMO : ready_at));
    check("req_latency", req_cyc - start_cyc, 1);
    check("resp_req_low", bus_req, 1'b0);
    check("resp_bus_err", bus_err, timed_out);
    check_rdata("resp_rdata");
    last_resp = cyc;
    last_req  = req_cyc;
    bus_ready = 1'b0; memreadM = 1'b0; memwriteM = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Misaligned access: dropped, no stall, single addr_err pulse.
  task automatic misaligned(input bit wr, input logic [31:0] addr);
    if (!wr) rdata_model = '0;
    exp_q.push_back(rdata_model);
    memreadM = !wr; memwriteM = wr; addrM = addr; wdataM = 32'h1111_2222;
    #1;
    check("mis_stall", stallM, 1'b0);
    @(posedge clk);
    @(negedge clk);
    memreadM = 1'b0; memwriteM = 1'b0;
    #1;
    check("mis_addr_err", addr_err, 1'b1);
    check("mis_no_req", bus_req, 1'b0);
    check_rdata("mis_rdata");
    @(posedge clk);
    #1;
    check("mis_addr_err_single", addr_err, 1'b0);
    check("mis_no_req_after", bus_req, 1'b0);
    @(negedge clk);
  endtask

  // Idle cycles, optionally with a stray bus_ready that must be ignored.
  task automatic idle(input int n, input bit stray_ready);
    for (int i = 0; i < n; i++) begin
      bus_ready = stray_ready;
      bus_rdata = 32'hFFFF_0000;
      #1;
      check("idle_stall", stallM, 1'b0);
      check("idle_req", bus_req, 1'b0);
      check("idle_rdata_hold", rdataM, rdata_model);
      @(negedge clk);
    end
    bus_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    memreadM = 1'b0; memwriteM = 1'b0; addrM = '0; wdataM = '0;
    bus_ready = 1'b0; bus_rdata = '0;
    #3;
    check("rst_rdata", rdataM, 32'h0);
    check("rst_stall", stallM, 1'b0);
    check("rst_addr_err", addr_err, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_req", bus_req, 1'b0);
    check("rst_we", bus_we, 1'b0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Load with ready in the third WAIT cycle: 4 stall cycles.
    run_xfer(1'b0, 32'h0000_0100, 32'h0, 3, 32'h1234_5678);
    // Store with ready in the first WAIT cycle; rdataM must not change.
    run_xfer(1'b1, 32'h0000_0204, 32'hCAFE_F00D, 1, 32'h5555_5555);
    idle(2, 1'b0);

    // Misaligned load and store.
    misaligned(1'b0, 32'h0000_0102);
    misaligned(1'b1, 32'h0000_0206);
    idle(1, 1'b0);

    // Timed-out load returns the error pattern and pulses bus_err.
    run_xfer(1'b0, 32'h0000_0300, 32'h0, 0, 32'h0);
    #1;
    check("bus_err_single", bus_err, 1'b0);
    @(negedge clk);

    // Back-to-back load then store: second request 2 cycles after first RESP.
    run_xfer(1'b0, 32'h0000_0400, 32'h0, 2, 32'hA5A5_0001);
    begin
      int resp_a;
      resp_a = last_resp;
      run_xfer(1'b1, 32'h0000_0404, 32'h0BAD_CAFE, 1, 32'h7777_7777);
      check("b2b_gap", last_req - resp_a, 2);
    end

    // Stray ready with no request outstanding.
    idle(2, 1'b1);

    // Reset asserted mid-WAIT abandons the transfer.
    memreadM = 1'b1; addrM = 32'h0000_0600;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("pre_rst_req", bus_req, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_req", bus_req, 1'b0);
    check("mid_rst_stall", stallM, 1'b0);
    check("mid_rst_bus_err", bus_err, 1'b0);
    memreadM = 1'b0;
    rdata_model = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_bus_err", bus_err, 1'b0);
    @(negedge clk);
    run_xfer(1'b0, 32'h0000_0500, 32'h0, 2, 32'h0BAD_F00D);
    idle(1, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
- Data-memory controller directly downstream of the MIPS core's MEM stage.
- Consumes the core's memwriteM/memreadM, ALU address and store data. Returns read data to the core.
- Drives a variable-latency, single-outstanding req/ready bus to the data SRAM/peripheral fabric.
- Asserts stallM to freeze the pipeline while a bus transaction is pending. Flags misaligned word accesses and bus timeouts.

Parameters:
- TIMEOUT_CYC, 255: wait cycles allowed for bus_ready before abort; legal range 1..255.
- ERR_RDATA, 32'hDEAD_BEEF: value returned on rdataM after a timed-out read.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- memreadM  in  1  MEM-stage load.
- memwriteM  in  1  MEM-stage store.
- addrM  in  32  byte address (core aluout).
- wdataM  in  32  store data (core writedata).
- rdataM  out  32  load data to core (core readdata).
- stallM  out  1  hold MEM stage and everything upstream.
- addr_err  out  1  one-cycle pulse: misaligned access dropped.
- bus_err  out  1  one-cycle pulse: bus timeout.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  1 = write, registered.
- bus_addr  out  32  word-aligned address, registered.
- bus_wdata  out  32  write data, registered.
- bus_ready  in  1  bus completes the transfer this cycle.
- bus_rdata  in  32  read data, valid when bus_ready=1.

Behaviour:
- Reset: state=IDLE, timeout counter=0, all outputs 0 (rdataM=0, stallM=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, addr_err=0, bus_err=0).
- States: IDLE, WAIT, RESP.
- access = memreadM|memwriteM. Both set is illegal; the block treats it as a write.
- IDLE, access with addrM[1:0]!=0:
  - no bus activity; stallM=0.
  - addr_err pulses the next cycle.
  - rdataM=0 for a load.
- IDLE, aligned access:
  - stallM=1 combinationally in the same cycle.
  - Latch bus_addr={addrM[31:2],2'b00}, bus_wdata, bus_we.
  - bus_req=1 from the next cycle; go to WAIT.
- WAIT:
  - stallM=1. bus_req, bus_we, bus_addr and bus_wdata stay stable until bus_ready is sampled high.
  - Counter increments each cycle.
  - On bus_ready: capture bus_rdata into rdataM on reads; rdataM is unchanged on writes. Drop bus_req next cycle; go to RESP.
  - If counter reaches TIMEOUT_CYC with no ready: drop bus_req, rdataM=ERR_RDATA on reads, pulse bus_err, go to RESP.
- RESP:
  - stallM=0 and rdataM is valid; the core advances at the end of this cycle.
  - Unconditional transition to IDLE. The next MEM instruction is seen in IDLE, so no bubble.
- Latency: request in cycle 0, bus_req in cycle 1. Ready in cycle n gives RESP in cycle n+1. Minimum 2 stall cycles.
- rdataM holds its value until the next completed read.
- A bus_ready seen while bus_req=0 is ignored.
- Async reset mid-transaction: bus_req drops immediately and the transaction is abandoned; no bus_err.

Optional Feature:
- Macro: DMEM_WRITE_BUFFER_EN.
- Defined:
  - Aligned stores in IDLE enter a 1-entry posted write buffer with stallM=0.
  - The buffer drains on the bus in the background.
  - Any access while the buffer is occupied stalls until it drains, then proceeds normally. Loads never bypass the buffer.
  - A drain timeout pulses bus_err and the buffer is discarded.
- Undefined: all stores follow the blocking path above.

Decomposition:
- Package dmem_bus_pkg: state encoding (IDLE/WAIT/RESP), ERR_RDATA default, word-align mask, timeout counter width (8).
- One natural sub-module: bus_timeout_cnt, a clear/enable counter with terminal-count output.
- FSM and datapath registers stay in dmem_bus_ctrl.

Test Plan:
- Load addr 0x100, bus_ready after 3 wait cycles with bus_rdata=0x12345678 -> bus_addr=0x100 held stable, stallM high for 4 cycles, rdataM=0x12345678 in RESP.
- Store 0xCAFEF00D to 0x204, ready in first WAIT cycle -> bus_we=1, bus_wdata=0xCAFEF00D, 2 stall cycles, rdataM unchanged.
- Load addr 0x102 -> no bus_req, stallM=0, addr_err single pulse.
- Load with bus_ready never asserted, TIMEOUT_CYC=4 -> bus_req drops after 4 WAIT cycles, bus_err pulse, rdataM=0xDEADBEEF.
- Back-to-back load then store -> second bus_req begins exactly 2 cycles after the first RESP; no extra bubble.
- rst low during WAIT -> bus_req=0 and stallM=0 immediately; clean load succeeds after release (DMEM_WRITE_BUFFER_EN: store then load -> store hits bus first, load stalls until drain).
